// File: rtl/adc_fft_framer_if.sv
// AXI-Stream channels between the ADC framer and the FFT core: the one-shot
// config channel and the complex sample data channel.
interface adc_fft_framer_if;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [7:0]  cfg_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;

    modport master (
        output cfg_tvalid, cfg_tdata, m_tvalid, m_tdata, m_tlast,
        input  cfg_tready, m_tready
    );

    modport slave (
        input  cfg_tvalid, cfg_tdata, m_tvalid, m_tdata, m_tlast,
        output cfg_tready, m_tready
    );
endinterface

// File: rtl/adc_fft_framer.sv
// Captures XADC results, converts them to signed complex samples, buffers them
// and streams FFT frames with tlast every FRAME_LEN beats.
//
// state  | meaning
// CONFIG | offering the FFT config word; ADC samples are discarded
// STREAM | capturing ADC samples and streaming framed beats
module adc_fft_framer #(
    parameter int          FRAME_LEN  = 64,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  CFG_WORD   = 8'h01
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    input  logic [15:0]              adc_data,
    input  logic                     adc_drdy,
    adc_fft_framer_if.master         axis,
    output logic                     overflow,
    output logic [15:0]              frame_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(FRAME_LEN) + 1;

    typedef enum logic {CONFIG, STREAM} state_t;

    state_t         state;
    logic           cfg_valid_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic [15:0]    out_real_q;
    logic [IW-1:0]  beats_left;

    logic [15:0]    mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic           push_ok;
    logic           beat_done;
    logic [15:0]    sample_real;
    logic           unused_lsbs;

    // Offset-binary 12-bit sample to signed Q15: subtract mid-scale, scale by 16.
    assign sample_real = {~adc_data[15], adc_data[14:4], 4'b0000};
    assign unused_lsbs = ^adc_data[3:0];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign beat_done  = out_valid_q && axis.m_tready;
    assign push       = (state == STREAM) && adc_drdy;
    // Refill the output register whenever it is empty or draining this edge.
    assign pop        = !fifo_empty && (!out_valid_q || axis.m_tready);
    assign push_ok    = push && (!fifo_full || pop);

    assign axis.cfg_tvalid = cfg_valid_q;
    assign axis.cfg_tdata  = CFG_WORD;
    assign axis.m_tvalid   = out_valid_q;
    assign axis.m_tdata    = {16'h0000, out_real_q};
    assign axis.m_tlast    = out_last_q;

    always_ff @(posedge CLK100MHZ) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= sample_real;
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state       <= CONFIG;
            cfg_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_real_q  <= 16'h0000;
            beats_left  <= IW'(FRAME_LEN);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            case (state)
                CONFIG: begin
                    if (cfg_valid_q && axis.cfg_tready) begin
                        cfg_valid_q <= 1'b0;
                        state       <= STREAM;
                    end else begin
                        cfg_valid_q <= 1'b1;
                    end
                end
                STREAM: begin
                    cfg_valid_q <= 1'b0;
                end
                default: begin
                    state       <= CONFIG;
                    cfg_valid_q <= 1'b0;
                end
            endcase

            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (push && fifo_full && !pop)
                overflow <= 1'b1;

            // Every loaded beat is eventually accepted, so counting loads
            // down from FRAME_LEN tracks the accepted-beat frame index.
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                out_real_q  <= mem[rd_ptr[AW-1:0]];
                out_valid_q <= 1'b1;
                out_last_q  <= (beats_left == IW'(1));
                beats_left  <= (beats_left == IW'(1)) ? IW'(FRAME_LEN) : beats_left - 1'b1;
            end else if (beat_done) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            if (beat_done && out_last_q)
                frame_count <= frame_count + 16'd1;
        end
    end
endmodule
